sram_resp_confreg: RTL and testbench

//   Responder end of the core's SRAM-style data port (en/wen/addr/wdata -> rdata).

---
 rtl/sram_resp_confreg.sv | 134 +++++++++++++
 tb/tb_sram_resp_confreg.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sram_resp_confreg.sv
// SRAM-style data-port responder: word RAM plus LED/switch/timer/scratch config window.
// Optional counter: define CONF_TIMER_EN to build the TIMER register at offset 0x0008.
`default_nettype none

module sram_resp_confreg #(
  parameter int          RAM_AW  = 14,
  parameter logic [15:0] CONF_HI = 16'h1faf,
  parameter int          LED_W   = 16,
  parameter int          SW_W    = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [3:0]       wen,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led
);

  localparam logic [15:0] OFF_LED     = 16'h0000;
  localparam logic [15:0] OFF_SWITCH  = 16'h0004;
  localparam logic [15:0] OFF_TIMER   = 16'h0008;
  localparam logic [15:0] OFF_SCRATCH = 16'h000c;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    return res;
  endfunction

  logic              conf_sel;
  logic [15:0]       offset;
  logic [RAM_AW-1:0] ram_idx;
  logic              conf_wr;
  logic [31:0]       conf_rd;
  logic              unused_addr_lsb;

  assign conf_sel        = (addr[31:16] == CONF_HI);
  assign offset          = addr[15:0];
  assign ram_idx         = addr[RAM_AW+1:2];
  assign conf_wr         = en && conf_sel && (wen != 4'b0000);
  assign unused_addr_lsb = ^addr[1:0];

  // RAM has no reset, so writes land even while resetn is low.
  logic [31:0] mem [0:(1<<RAM_AW)-1];
  logic [31:0] ram_q;

  always_ff @(posedge clk) begin
    if (en && !conf_sel) begin
      ram_q <= mem[ram_idx];
      for (int i = 0; i < 4; i++)
        if (wen[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  logic [SW_W-1:0] sw_meta, sw_sync;
  logic [31:0]     scratch;
  logic [31:0]     timer_val;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      led     <= '0;
      scratch <= '0;
    end else if (conf_wr) begin
      if (offset == OFF_LED)
        led <= LED_W'(byte_merge(32'(led), wdata, wen));
      if (offset == OFF_SCRATCH)
        scratch <= byte_merge(scratch, wdata, wen);
    end
  end

`ifdef CONF_TIMER_EN
  logic [31:0] timer;

  // Free-running; a write in the same cycle overrides the increment.
  always_ff @(posedge clk) begin
    if (!resetn)
      timer <= '0;
    else if (conf_wr && offset == OFF_TIMER)
      timer <= byte_merge(timer, wdata, wen);
    else
      timer <= timer + 32'd1;
  end

  assign timer_val = timer;
`else
  assign timer_val = '0;
`endif

  always_comb begin
    conf_rd = '0;
    case (offset)
      OFF_LED:     conf_rd = 32'(led);
      OFF_SWITCH:  conf_rd = 32'(sw_sync);
      OFF_TIMER:   conf_rd = timer_val;
      OFF_SCRATCH: conf_rd = scratch;
      default:     conf_rd = '0;
    endcase
  end

  // Output select is a flop; resetting it to the (zeroed) config path gives rdata=0.
  logic        src_ram_q;
  logic [31:0] conf_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      src_ram_q <= 1'b0;
      conf_q    <= '0;
    end else if (en) begin
      src_ram_q <= !conf_sel;
      conf_q    <= conf_sel ? conf_rd : 32'h0;
    end
  end

  assign rdata = src_ram_q ? ram_q : conf_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_resp_confreg.sv
// Directed self-checking bench for sram_resp_confreg.
`default_nettype none

module tb_sram_resp_confreg;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  sw;
  logic [15:0] led;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A_LED  = 32'h1faf_0000;
  localparam logic [31:0] A_SW   = 32'h1faf_0004;
  localparam logic [31:0] A_TMR  = 32'h1faf_0008;
  localparam logic [31:0] A_SCR  = 32'h1faf_000c;
  localparam logic [31:0] A_NONE = 32'h1faf_0010;

  always #5 clk = ~clk;

  sram_resp_confreg dut (
    .clk    (clk),
    .resetn (resetn),
    .en     (en),
    .wen    (wen),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .sw     (sw),
    .led    (led)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One request cycle; returns at the negedge after the capturing edge.
  task automatic do_req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; wen = w; addr = a; wdata = d;
    @(negedge clk);
    en = 1'b0; wen = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0; sw = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_led", 32'(led), 32'h0);
    resetn = 1'b1;

    // RAM round trip and aliasing of upper address bits
    do_req(4'hf, 32'h1000_0010, 32'hdeadbeef);
    do_req(4'h0, 32'h1000_0010, 32'h0);
    check("ram_rd", rdata, 32'hdeadbeef);
    do_req(4'h0, 32'h2000_0010, 32'h0);
    check("ram_alias", rdata, 32'hdeadbeef);
    @(negedge clk);
    check("rdata_hold", rdata, 32'hdeadbeef);

    // Byte enables with read-first
    do_req(4'hf, 32'h0000_0100, 32'h11223344);
    do_req(4'b0101, 32'h0000_0100, 32'haabbccdd);
    check("be_readfirst", rdata, 32'h11223344);
    do_req(4'h0, 32'h0000_0100, 32'h0);
    check("be_merge", rdata, 32'h11bb33dd);

    do_req(4'hf, 32'h0000_0200, 32'h7);
    do_req(4'hf, 32'h0000_0200, 32'h5);
    check("readfirst_old", rdata, 32'h7);
    do_req(4'h0, 32'h0000_0200, 32'h0);
    check("readfirst_new", rdata, 32'h5);

    // LED full and partial writes
    do_req(4'hf, A_LED, 32'h0000_a5a5);
    check("led_wr", 32'(led), 32'h0000_a5a5);
    check("led_wr_readfirst", rdata, 32'h0);
    do_req(4'b0010, A_LED, 32'hffff_3cff);
    check("led_partial", 32'(led), 32'h0000_3ca5);
    do_req(4'h0, A_LED, 32'h0);
    check("led_rd", rdata, 32'h0000_3ca5);

    // Scratch and unmapped offset
    do_req(4'hf, A_SCR, 32'h1234_5678);
    do_req(4'h0, A_SCR, 32'h0);
    check("scratch_rd", rdata, 32'h1234_5678);
    do_req(4'hf, A_NONE, 32'hffff_ffff);
    do_req(4'h0, A_NONE, 32'h0);
    check("unmapped_rd", rdata, 32'h0);

    // Switch synchroniser
    sw = 8'h3c;
    repeat (2) @(posedge clk);
    do_req(4'h0, A_SW, 32'h0);
    check("switch_rd", rdata, 32'h0000_003c);

    // Timer write then back-to-back reads across the wrap
    @(negedge clk);
    en = 1'b1; wen = 4'hf; addr = A_TMR; wdata = 32'hffff_fffe;
    @(negedge clk);
    wen = 4'h0;
    @(negedge clk);
`ifdef CONF_TIMER_EN
    check("timer_0", rdata, 32'hffff_fffe);
    @(negedge clk);
    check("timer_1", rdata, 32'hffff_ffff);
    @(negedge clk);
    check("timer_wrap", rdata, 32'h0);
`else
    check("timer_0", rdata, 32'h0);
    @(negedge clk);
    check("timer_1", rdata, 32'h0);
    @(negedge clk);
    check("timer_wrap", rdata, 32'h0);
`endif
    en = 1'b0;

    // Reset during writes: LED write dropped, RAM write kept
    do_req(4'hf, 32'h0000_0300, 32'h0);
    @(negedge clk);
    resetn = 1'b0;
    en = 1'b1; wen = 4'hf; addr = A_LED; wdata = 32'h0000_1234;
    @(negedge clk);
    addr = 32'h0000_0300; wdata = 32'hcafe_f00d;
    @(negedge clk);
    check("rst_led", 32'(led), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    // Timer reads 0 on the first edge out of reset
    resetn = 1'b1; wen = 4'h0; addr = A_TMR;
    @(negedge clk);
    en = 1'b0;
    check("timer_after_rst", rdata, 32'h0);
    do_req(4'h0, 32'h0000_0300, 32'h0);
    check("ram_wr_in_rst", rdata, 32'hcafe_f00d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
